xeng_corr_apply: RTL and testbench

- Downstream counterpart of the X-engine component tracker. It consumes the per-baseline real and imaginary correction terms that the tracker produces.
- Applies those terms, plus a fixed offset-binary constant, to the raw accumulated X-engine products. This turns correlations computed on offset-binary real parts back into true signed visibilities.
- Sits between the X-engine tap-chain accumulator output and the vector-accumulator / packetiser.

---
 rtl/xeng_corr_pkg.sv | 41 ++++
 rtl/corr_fifo.sv | 71 +++++++
 rtl/xeng_corr_apply.sv | 147 ++++++++++++++
 tb/tb_xeng_corr_apply.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xeng_corr_pkg.sv
// Shared constants for the X-engine correction-apply block.
// Holds the build parameters, the derived correction width and offset-binary
// constants, and the component ordering used by the acc_din/dout packing
// {xx_re,xx_im,xy_re,xy_im,yx_re,yx_im,yy_re,yy_im} (MSB first).
package xeng_corr_pkg;

    localparam int unsigned SERIAL_ACC_LEN_BITS = 7;
    localparam int unsigned P_FACTOR_BITS       = 2;
    localparam int unsigned BITWIDTH            = 4;
    localparam int unsigned N_ANTS              = 32;
    localparam int unsigned ACC_WIDTH           = 32;
    localparam int unsigned FIFO_DEPTH_BITS     = 3;

    // Width of one tracker correction term.
    function automatic int unsigned corr_width(input int unsigned p,
                                               input int unsigned s,
                                               input int unsigned b);
        return p + s + b + 3;
    endfunction

    localparam int unsigned CW       = corr_width(P_FACTOR_BITS, SERIAL_ACC_LEN_BITS, BITWIDTH);
    localparam int unsigned SHIFT    = BITWIDTH - 1;
    localparam int unsigned N_SAMP   = 1 << (P_FACTOR_BITS + SERIAL_ACC_LEN_BITS);
    localparam int unsigned RE_CONST = N_SAMP << (2 * SHIFT);

    localparam int unsigned N_COMP = 8;
    localparam int unsigned W_EXT  = ACC_WIDTH + 2;
    localparam int unsigned BL_MAX = N_ANTS / 2;
    localparam int unsigned BL_W   = $clog2(BL_MAX + 1);

    // Component index within the packed bus; index 0 occupies the MSBs.
    localparam int unsigned IDX_XX_RE = 0;
    localparam int unsigned IDX_XX_IM = 1;
    localparam int unsigned IDX_XY_RE = 2;
    localparam int unsigned IDX_XY_IM = 3;
    localparam int unsigned IDX_YX_RE = 4;
    localparam int unsigned IDX_YX_IM = 5;
    localparam int unsigned IDX_YY_RE = 6;
    localparam int unsigned IDX_YY_IM = 7;

endpackage

// File: rtl/corr_fifo.sv
// First-word-fall-through FIFO for per-baseline correction sets.
// Ports: clk, rst (async, active high), flush (empties the FIFO; a same-cycle
// push lands as entry 0), push/din, pop (ignored when empty), dout (head),
// full, empty, count (occupancy).
module corr_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS:0]   cnt;
    logic                  pop_ok_c;
    logic                  push_ok_c;
    logic                  wr_en_c;
    logic [DEPTH_BITS-1:0] wr_addr_c;

    assign full  = (cnt == (DEPTH_BITS+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so push into a full FIFO succeeds then.
    assign pop_ok_c  = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok_c);
    assign wr_en_c   = flush ? push : push_ok_c;
    assign wr_addr_c = flush ? '0 : wr_ptr;

    // Storage: not reset, head is only consumed when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= DEPTH_BITS'(push);
            cnt    <= (DEPTH_BITS+1)'(push);
        end else begin
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            end
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            end
            cnt <= cnt + (DEPTH_BITS+1)'(push_ok_c) - (DEPTH_BITS+1)'(pop_ok_c);
        end
    end

endmodule

// File: rtl/xeng_corr_apply.sv
// Applies tracker corrections and the offset-binary constant to raw X-engine
// products, producing true signed visibilities.
// Ports: clk, rst (async, active high), sync (window start), corr_vld plus
// re_/im_corr_{xx,xy,yx,yy} (one baseline's corrections), acc_din/acc_vld (raw
// baseline), dout/dout_vld (corrected, 2-cycle latency), sync_out, bl_idx,
// sticky ovf_err / unf_err.
module xeng_corr_apply
    import xeng_corr_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sync,
    input  logic                          corr_vld,
    input  logic signed [CW-1:0]          re_corr_xx,
    input  logic signed [CW-1:0]          re_corr_xy,
    input  logic signed [CW-1:0]          re_corr_yx,
    input  logic signed [CW-1:0]          re_corr_yy,
    input  logic signed [CW-1:0]          im_corr_xx,
    input  logic signed [CW-1:0]          im_corr_xy,
    input  logic signed [CW-1:0]          im_corr_yx,
    input  logic signed [CW-1:0]          im_corr_yy,
    input  logic [N_COMP*ACC_WIDTH-1:0]   acc_din,
    input  logic                          acc_vld,
    output logic [N_COMP*ACC_WIDTH-1:0]   dout,
    output logic                          dout_vld,
    output logic                          sync_out,
    output logic [BL_W-1:0]               bl_idx,
    output logic                          ovf_err,
    output logic                          unf_err
);

    logic [N_COMP*CW-1:0]        corr_word_c;
    logic [N_COMP*CW-1:0]        head_c;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [FIFO_DEPTH_BITS:0]    fifo_count;
    logic                        head_valid_c;
    logic [BL_W-1:0]             bl_cnt;
    logic [BL_W-1:0]             bl_cur_c;
    logic                        s1_vld;
    logic                        s1_sync;
    logic [BL_W-1:0]             s1_bl;
    logic [N_COMP*ACC_WIDTH-1:0] s1_raw;
    logic [N_COMP*ACC_WIDTH-1:0] sat_c;

    // Same component order as acc_din so index k lines up on both buses.
    assign corr_word_c = {re_corr_xx, im_corr_xx, re_corr_xy, im_corr_xy,
                          re_corr_yx, im_corr_yx, re_corr_yy, im_corr_yy};

    corr_fifo #(
        .WIDTH      (N_COMP * CW),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (sync),
        .push  (corr_vld),
        .din   (corr_word_c),
        .pop   (acc_vld),
        .dout  (head_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_valid_c = (fifo_count != '0);

    // The sync baseline is always index 0.
    assign bl_cur_c = sync ? '0 : bl_cnt;

    // Baseline counter, sticky flags, S1 data path and S2 output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bl_cnt   <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
            s1_vld   <= 1'b0;
            s1_sync  <= 1'b0;
            s1_bl    <= '0;
            s1_raw   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            sync_out <= 1'b0;
            bl_idx   <= '0;
        end else begin
            if (acc_vld) begin
                bl_cnt <= (bl_cur_c == BL_W'(BL_MAX)) ? '0 : bl_cur_c + BL_W'(1);
            end else if (sync) begin
                bl_cnt <= '0;
            end
            // A flush makes room, so a push in a sync cycle never overflows.
            if (corr_vld && fifo_full && !acc_vld && !sync) begin
                ovf_err <= 1'b1;
            end
            if (acc_vld && fifo_empty) begin
                unf_err <= 1'b1;
            end
            s1_vld  <= acc_vld;
            s1_sync <= sync;
            if (acc_vld) begin
                s1_raw <= acc_din;
                s1_bl  <= bl_cur_c;
            end
            dout_vld <= s1_vld;
            sync_out <= s1_sync;
            if (s1_vld) begin
                dout   <= sat_c;
                bl_idx <= s1_bl;
            end
        end
    end

    // Per-component correction: S1 captures the shifted term, S2 subtracts and saturates.
    for (genvar k = 0; k < N_COMP; k++) begin : g_comp
        localparam int unsigned D_LSB = (N_COMP - 1 - k) * ACC_WIDTH;
        localparam int unsigned C_LSB = (N_COMP - 1 - k) * CW;
        localparam logic signed [W_EXT-1:0] K_C   = (k % 2 == 0) ? W_EXT'(RE_CONST) : '0;
        localparam logic signed [W_EXT-1:0] MAX_V = {3'b000, {(ACC_WIDTH-1){1'b1}}};
        localparam logic signed [W_EXT-1:0] MIN_V = {3'b111, {(ACC_WIDTH-1){1'b0}}};

        logic signed [CW-1:0]        head_comp_c;
        logic signed [W_EXT-1:0]     corr_q;
        logic signed [ACC_WIDTH-1:0] raw_c;
        logic signed [W_EXT-1:0]     raw_ext_c;
        logic signed [W_EXT-1:0]     diff_c;

        assign head_comp_c = head_c[C_LSB +: CW];

        // Empty FIFO contributes a zero correction; the constant still applies.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                corr_q <= '0;
            end else if (acc_vld) begin
                corr_q <= head_valid_c ? (W_EXT'(head_comp_c) <<< SHIFT) : '0;
            end
        end

        assign raw_c     = s1_raw[D_LSB +: ACC_WIDTH];
        assign raw_ext_c = W_EXT'(raw_c);
        assign diff_c    = raw_ext_c - corr_q - K_C;

        assign sat_c[D_LSB +: ACC_WIDTH] = (diff_c > MAX_V) ? MAX_V[ACC_WIDTH-1:0] :
                                           (diff_c < MIN_V) ? MIN_V[ACC_WIDTH-1:0] :
                                                              diff_c[ACC_WIDTH-1:0];
    end

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Directed bench for xeng_corr_apply with a scoreboard of expected outputs.
module tb_xeng_corr_apply;

    typedef struct packed {
        logic [255:0] d;
        logic [4:0]   bl;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               sync;
    logic               corr_vld;
    logic signed [15:0] re_corr_xx, re_corr_xy, re_corr_yx, re_corr_yy;
    logic signed [15:0] im_corr_xx, im_corr_xy, im_corr_yx, im_corr_yy;
    logic [255:0]       acc_din;
    logic               acc_vld;
    logic [255:0]       dout;
    logic               dout_vld;
    logic               sync_out;
    logic [4:0]         bl_idx;
    logic               ovf_err;
    logic               unf_err;

    logic [127:0] cur_c;
    logic [255:0] cur_raw;
    exp_t         sbq[$];
    logic [127:0] mq[$];
    int           mcnt;
    bit           exp_ovf;
    bit           exp_unf;
    int           n_assert;
    int           n_fail;

    xeng_corr_apply dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .corr_vld   (corr_vld),
        .re_corr_xx (re_corr_xx),
        .re_corr_xy (re_corr_xy),
        .re_corr_yx (re_corr_yx),
        .re_corr_yy (re_corr_yy),
        .im_corr_xx (im_corr_xx),
        .im_corr_xy (im_corr_xy),
        .im_corr_yx (im_corr_yx),
        .im_corr_yy (im_corr_yy),
        .acc_din    (acc_din),
        .acc_vld    (acc_vld),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .sync_out   (sync_out),
        .bl_idx     (bl_idx),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Correction word packing: component k at bits [(7-k)*16 +: 16].
    assign re_corr_xx = cur_c[127:112];
    assign im_corr_xx = cur_c[111:96];
    assign re_corr_xy = cur_c[95:80];
    assign im_corr_xy = cur_c[79:64];
    assign re_corr_yx = cur_c[63:48];
    assign im_corr_yx = cur_c[47:32];
    assign re_corr_yy = cur_c[31:16];
    assign im_corr_yy = cur_c[15:0];
    assign acc_din    = cur_raw;

    // Reference: raw - corr*2^3 - (32768 on real parts), clamped to 32-bit signed.
    function automatic logic [255:0] model(input logic [255:0] raw, input logic [127:0] c);
        logic [255:0] r;
        longint v, cc, d;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            v  = longint'($signed(raw[(7-k)*32 +: 32]));
            cc = longint'($signed(c[(7-k)*16 +: 16]));
            d  = v - cc * 64'sd8 - ((k % 2 == 0) ? 64'sd32768 : 64'sd0);
            if (d > 64'sd2147483647)       d = 64'sd2147483647;
            else if (d < -64'sd2147483648) d = -64'sd2147483648;
            r[(7-k)*32 +: 32] = d[31:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_c(input int k, input int v);
        cur_c[(7-k)*16 +: 16] = 16'(v);
    endtask

    task automatic set_raw(input int k, input logic [31:0] v);
        cur_raw[(7-k)*32 +: 32] = v;
    endtask

    task automatic rand_c();
        for (int k = 0; k < 8; k++) set_c(k, int'($urandom_range(0, 65535)));
    endtask

    task automatic rand_raw();
        for (int k = 0; k < 8; k++) set_raw(k, 32'($urandom));
    endtask

    // Drive one cycle and update the model in hardware order: pop, flush, push.
    task automatic step(input bit cv, input bit av, input bit sy);
        exp_t         e;
        logic [127:0] c;
        int           bl;
        corr_vld = cv;
        acc_vld  = av;
        sync     = sy;
        if (av) begin
            bl = sy ? 0 : mcnt;
            if (mq.size() > 0) begin
                c = mq.pop_front();
            end else begin
                c = '0;
                exp_unf = 1'b1;
            end
            e.d  = model(cur_raw, c);
            e.bl = 5'(bl);
            sbq.push_back(e);
            mcnt = (bl == 16) ? 0 : bl + 1;
        end else if (sy) begin
            mcnt = 0;
        end
        if (sy) mq.delete();
        if (cv) begin
            if (mq.size() < 8) mq.push_back(cur_c);
            else exp_ovf = 1'b1;
        end
        @(negedge clk);
        corr_vld = 1'b0;
        acc_vld  = 1'b0;
        sync     = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk(tag, 256'(sbq.size()), 256'(0));
    endtask

    // Scoreboard: every valid output must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && dout_vld) begin
            n_assert++;
            assert (sbq.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underrun: observed unexpected dout_vld=1 expected no output");
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("dout", dout, e.d);
                chk("bl_idx", 256'(bl_idx), 256'(e.bl));
            end
        end
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mcnt     = 0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        rst      = 1'b1;
        sync     = 1'b0;
        corr_vld = 1'b0;
        acc_vld  = 1'b0;
        cur_c    = '0;
        cur_raw  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_dout", dout, 256'(0));
        chk("rst_dout_vld", 256'(dout_vld), 256'(0));
        chk("rst_sync_out", 256'(sync_out), 256'(0));
        chk("rst_bl_idx", 256'(bl_idx), 256'(0));
        chk("rst_ovf", 256'(ovf_err), 256'(0));
        chk("rst_unf", 256'(unf_err), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic correction on xx
        cur_c = '0;
        set_c(0, 5);
        set_c(1, -2);
        step(1'b1, 1'b0, 1'b0);
        cur_raw = '0;
        set_raw(0, 32'd40000);
        set_raw(1, 32'd100);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("basic_xx_re", 256'(dout[255:224]), 256'(32'd7192));
        chk("basic_xx_im", 256'(dout[223:192]), 256'(32'd116));
        chk("basic_vld", 256'(dout_vld), 256'(1));
        chk("basic_bl", 256'(bl_idx), 256'(0));
        drain("basic_drain");

        // Window order with sync_out alignment and bl_idx wrap
        step(1'b0, 1'b0, 1'b1);
        chk("sync_out_d1", 256'(sync_out), 256'(0));
        step(1'b0, 1'b0, 1'b0);
        chk("sync_out_d2", 256'(sync_out), 256'(1));
        step(1'b0, 1'b0, 1'b0);
        chk("sync_out_d3", 256'(sync_out), 256'(0));
        for (int i = 0; i < 19; i++) begin
            rand_c();
            rand_raw();
            step(i < 18, i > 0, 1'b0);
        end
        drain("window_drain");
        chk("window_unf", 256'(unf_err), 256'(0));

        // Overflow: ninth push dropped; full FIFO with push+pop keeps occupancy
        for (int i = 0; i < 9; i++) begin
            rand_c();
            step(1'b1, 1'b0, 1'b0);
            if (i == 7) chk("ovf_before", 256'(ovf_err), 256'(0));
        end
        chk("ovf_set", 256'(ovf_err), 256'(exp_ovf));
        rand_c();
        rand_raw();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rand_raw();
            step(1'b0, 1'b1, 1'b0);
        end
        drain("ovf_drain");
        chk("ovf_no_unf", 256'(unf_err), 256'(0));

        // Underflow: zero corrections, constant still applied
        cur_raw = '0;
        set_raw(0, 32'd32768);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("unf_xx_re", 256'(dout[255:224]), 256'(0));
        chk("unf_flag", 256'(unf_err), 256'(1));
        // Same-cycle push on empty does not bypass to the data
        rand_c();
        rand_raw();
        step(1'b1, 1'b1, 1'b0);
        rand_raw();
        step(1'b0, 1'b1, 1'b0);
        drain("unf_drain");
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("unf_sticky", 256'(unf_err), 256'(exp_unf));
        chk("ovf_sticky", 256'(ovf_err), 256'(exp_ovf));

        // Saturation at both rails
        cur_c = '0;
        set_c(6, 100);
        set_c(7, -32768);
        set_c(0, -32768);
        step(1'b1, 1'b0, 1'b0);
        cur_raw = '0;
        set_raw(6, 32'h8000_0000);
        set_raw(7, 32'h7FFF_FFFF);
        set_raw(0, 32'h7FFF_FFFF);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("sat_yy_re", 256'(dout[63:32]), 256'(32'h8000_0000));
        chk("sat_yy_im", 256'(dout[31:0]), 256'(32'h7FFF_FFFF));
        chk("sat_xx_re", 256'(dout[255:224]), 256'(32'h7FFF_FFFF));
        drain("sat_drain");

        // Async reset with a baseline in S1 and three queued corrections
        for (int i = 0; i < 4; i++) begin
            rand_c();
            step(1'b1, 1'b0, 1'b0);
        end
        rand_raw();
        step(1'b0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        mq.delete();
        sbq.delete();
        mcnt    = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #1;
        chk("arst_vld", 256'(dout_vld), 256'(0));
        chk("arst_ovf", 256'(ovf_err), 256'(0));
        chk("arst_unf", 256'(unf_err), 256'(0));
        repeat (2) @(negedge clk);
        chk("arst_vld_hold", 256'(dout_vld), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("arst_quiet", 256'(dout_vld), 256'(0));
        rand_c();
        step(1'b1, 1'b0, 1'b0);
        rand_raw();
        step(1'b0, 1'b1, 1'b0);
        drain("arst_drain");
        chk("arst_unf_after", 256'(unf_err), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
